motion_arbiter: RTL and testbench
=================================

MOTION_ARBITER -- requirements
Module: motion_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4: STOP cycles inserted between any two grants.
REQ-002 SHALL have parameter MAX_HOLD, default 1000: watchdog hold limit in cycles (used only under MOTION_ARB_WDOG_EN).
REQ-003 SHALL have parameter CW, default 16: width of the hold and gap counters; it SHALL hold MAX_HOLD and GAP_CYCLES.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port req, input, 3: request lines. Bit 0 is obstacle avoidance, bit 1 is remote command, bit 2 is line follower.
REQ-007 SHALL have ports dir0, dir1, dir2, input, 2 each: the requested direction of requesters 0, 1 and 2.
REQ-008 SHALL have port grant, output reg, 3: one-hot grant, or zero when nothing is granted.
REQ-009 SHALL have port direction, output reg, 2: drive command, encoded STOP=00, FORWARD=01, LEFT=10, RIGHT=11.
REQ-010 SHALL have port busy, output reg, 1: high whenever the state is not IDLE.

Function
REQ-011 SHALL implement the states IDLE, GRANT and GAP; all outputs are registered.
REQ-012 In IDLE, grant SHALL be 000 and direction SHALL be STOP.
REQ-013 In IDLE, if any req bit is high in cycle N, the block SHALL arbitrate and present grant and direction in cycle N+1 (state GRANT).
REQ-014 Arbitration: req[0] SHALL win if set; otherwise req[1] and req[2] SHALL be served round-robin using a last-served pointer.
REQ-015 After reset the round-robin pointer SHALL favour req[1].
REQ-016 After requester 1 or 2 is granted, the pointer SHALL favour the other of the two.
REQ-017 In GRANT, direction SHALL equal the dir input of the granted requester, sampled the previous cycle (1-cycle latency).
REQ-018 In GRANT, grant SHALL stay constant.
REQ-019 When the granted req bit is low at a rising edge, the block SHALL enter GAP.
REQ-020 When req[0] is high while grant is 010 or 100, the block SHALL enter GAP on the next edge (preemption, no minimum hold).
REQ-021 In GAP, grant SHALL be 000 and direction SHALL be STOP for exactly GAP_CYCLES cycles.
REQ-022 At the end of GAP, arbitration SHALL use req as sampled on the last GAP cycle; with no request pending the block SHALL go to IDLE.
REQ-023 If req drops and req[0] rises in the same cycle, the block SHALL take one GAP, then grant requester 0.
REQ-024 Requests arriving during GAP SHALL NOT shorten it.
REQ-025 While requester 0 is granted, requesters 1 and 2 SHALL wait without limit.
REQ-026 With GAP_CYCLES=0, the switch SHALL still insert one STOP cycle.
REQ-027 The hold counter SHALL count cycles in GRANT, clear on entry to GRANT, and saturate at 2^CW-1.

Reset
REQ-028 While rst is high at a rising edge, the block SHALL enter IDLE and set grant=000, direction=STOP, busy=0, counters=0 and the pointer to favour req[1].
REQ-029 Reset asserted in the middle of a grant or GAP SHALL take effect on that edge, with no partial gap completed.
REQ-030 The first grant after rst deasserts SHALL follow REQ-013 timing.

Configuration
REQ-031 Macro MOTION_ARB_WDOG_EN defined: if requester 1 or 2 is granted and has held for MAX_HOLD cycles while the other of the two is requesting, the block SHALL force GAP and then grant the waiting one.
REQ-032 Macro MOTION_ARB_WDOG_EN undefined: there SHALL be no forced release; requesters 1 and 2 switch only on release or on req[0] preemption.

Verification
REQ-033 Reset, then req=010 with dir1=01 at cycle 0 -> cycle 1: grant=010, direction=01, busy=1.
REQ-034 req=110 held from IDLE, then req[1] dropped at cycle 5 -> grant=010 first, then 4 cycles of STOP with grant=000, then grant=100 with direction=dir2.
REQ-035 Requester 2 granted with dir2=10, then req[0] rises with dir0=11 -> next cycle grant=000 and direction=00 for 4 cycles, then grant=001 and direction=11.
REQ-036 WDOG_EN with MAX_HOLD=8: req=110 held constant -> grant alternates 010 and 100, each held 8 cycles and separated by a 4-cycle STOP gap. Without the macro, grant stays 010 indefinitely.
REQ-037 rst pulsed for 1 cycle during GAP -> next cycle IDLE with all outputs 0; req=110 then grants 010 first (pointer reset).

Source files
------------

// File: rtl/motion_arbiter.sv
// Three-requester motion arbiter: fixed priority for obstacle avoidance, round-robin
// between remote command and line follower, with a mandatory STOP gap between grants.
// Optional hold watchdog enabled by defining MOTION_ARB_WDOG_EN.
module motion_arbiter #(
  parameter int GAP_CYCLES = 4,
  parameter int MAX_HOLD   = 1000,
  parameter int CW         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [1:0] dir0,
  input  logic [1:0] dir1,
  input  logic [1:0] dir2,
  output logic [2:0] grant,
  output logic [1:0] direction,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [1:0]    DIR_STOP  = 2'b00;
  // A zero-length gap still costs one STOP cycle, so the last gap index never goes below 0.
  localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  state_t        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [1:0]    direction_q, direction_d;
  logic          busy_q, busy_d;
  logic          favor2_q, favor2_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [CW-1:0] hold_q, hold_d;

  logic [2:0] pick;
  logic       release_evt;
  logic       preempt_evt;
  logic       wdog_evt;

  function automatic logic [2:0] arbitrate(input logic [2:0] r, input logic favor2);
    logic [2:0] g;
    g = 3'b000;
    if (r[0])              g = 3'b001;
    else if (r[1] && r[2]) g = favor2 ? 3'b100 : 3'b010;
    else if (r[1])         g = 3'b010;
    else if (r[2])         g = 3'b100;
    return g;
  endfunction

  function automatic logic [1:0] dir_of(input logic [2:0] g, input logic [1:0] d0,
                                        input logic [1:0] d1, input logic [1:0] d2);
    logic [1:0] d;
    d = DIR_STOP;
    case (g)
      3'b001:  d = d0;
      3'b010:  d = d1;
      3'b100:  d = d2;
      default: d = DIR_STOP;
    endcase
    return d;
  endfunction

  assign pick        = arbitrate(req, favor2_q);
  assign release_evt = ~|(req & grant_q);
  assign preempt_evt = req[0] & ~grant_q[0];

`ifdef MOTION_ARB_WDOG_EN
  assign wdog_evt = (hold_q >= HOLD_LAST) &&
                    ((grant_q[1] && req[2]) || (grant_q[2] && req[1]));
`else
  assign wdog_evt = 1'b0;
`endif

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    direction_d = direction_q;
    favor2_d    = favor2_q;
    gap_d       = gap_q;
    hold_d      = hold_q;

    case (state_q)
      S_GRANT: begin
        hold_d      = (hold_q == CNT_MAX) ? hold_q : hold_q + 1'b1;
        direction_d = dir_of(grant_q, dir0, dir1, dir2);
        if (release_evt || preempt_evt || wdog_evt) begin
          state_d     = S_GAP;
          grant_d     = 3'b000;
          direction_d = DIR_STOP;
          gap_d       = '0;
        end
      end
      S_GAP: begin
        grant_d     = 3'b000;
        direction_d = DIR_STOP;
        if (gap_q >= GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        grant_d     = 3'b000;
        direction_d = DIR_STOP;
      end
    endcase

    // IDLE and the final gap cycle share one launch path into GRANT.
    if ((state_q == S_IDLE || (state_q == S_GAP && gap_q >= GAP_LAST)) && |req) begin
      state_d     = S_GRANT;
      grant_d     = pick;
      direction_d = dir_of(pick, dir0, dir1, dir2);
      hold_d      = '0;
      if (pick[1]) favor2_d = 1'b1;
      if (pick[2]) favor2_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= 3'b000;
      direction_q <= DIR_STOP;
      busy_q      <= 1'b0;
      favor2_q    <= 1'b0;
      gap_q       <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      direction_q <= direction_d;
      busy_q      <= busy_d;
      favor2_q    <= favor2_d;
      gap_q       <= gap_d;
      hold_q      <= hold_d;
    end
  end

  assign grant     = grant_q;
  assign direction = direction_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_motion_arbiter.sv
// Scoreboard bench for motion_arbiter: directed steps push expected outputs,
// a monitor pops one entry per clock and compares against the selected instance.
module tb_motion_arbiter;

  typedef struct {
    int         sel;   // 0: main instance, 1: zero-gap instance, 2: no check
    logic [2:0] g;
    logic [1:0] d;
    logic       b;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [1:0] dir0, dir1, dir2;
  logic [2:0] grant_a, grant_z;
  logic [1:0] direction_a, direction_z;
  logic       busy_a, busy_z;

  logic [1:0] td0, td1, td2;
  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  motion_arbiter #(.GAP_CYCLES(4), .MAX_HOLD(8), .CW(16)) u_dut (
    .clk(clk), .rst(rst), .req(req), .dir0(dir0), .dir1(dir1), .dir2(dir2),
    .grant(grant_a), .direction(direction_a), .busy(busy_a)
  );

  motion_arbiter #(.GAP_CYCLES(0), .MAX_HOLD(8), .CW(16)) u_dut_g0 (
    .clk(clk), .rst(rst), .req(req), .dir0(dir0), .dir1(dir1), .dir2(dir2),
    .grant(grant_z), .direction(direction_z), .busy(busy_z)
  );

  // Apply inputs for the next rising edge and queue the outputs expected after it.
  task automatic step(input logic r_rst, input logic [2:0] r, input int sel,
                      input logic [2:0] eg, input logic [1:0] ed, input logic eb,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst  = r_rst;
    req  = r;
    dir0 = td0;
    dir1 = td1;
    dir2 = td2;
    e.sel = sel; e.g = eg; e.d = ed; e.b = eb; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [2:0] ag;
    logic [1:0] ad;
    logic       ab;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e  = sb.pop_front();
        ag = (e.sel == 1) ? grant_z     : grant_a;
        ad = (e.sel == 1) ? direction_z : direction_a;
        ab = (e.sel == 1) ? busy_z      : busy_a;
        if (e.sel != 2) begin
          n_tests++;
          if (ag !== e.g || ad !== e.d || ab !== e.b) begin
            n_fail++;
            $display("FAIL %s: got grant=%b dir=%b busy=%b, expected grant=%b dir=%b busy=%b",
                     e.name, ag, ad, ab, e.g, e.d, e.b);
          end
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; req = 3'b000; dir0 = 2'b00; dir1 = 2'b00; dir2 = 2'b00;
    td0 = 2'b11; td1 = 2'b01; td2 = 2'b10;

    step(1, 3'b000, 0, 3'b000, 2'b00, 0, "reset");
    step(1, 3'b000, 0, 3'b000, 2'b00, 0, "reset_hold");

    // First grant, direction tracking, release and full gap back to IDLE.
    step(0, 3'b010, 0, 3'b010, 2'b01, 1, "first_grant");
    td1 = 2'b10;
    step(0, 3'b010, 0, 3'b010, 2'b10, 1, "dir_track");
    step(0, 3'b000, 0, 3'b000, 2'b00, 1, "release_gap");
    for (int i = 0; i < 3; i++) step(0, 3'b000, 0, 3'b000, 2'b00, 1, "gap_hold");
    step(0, 3'b000, 0, 3'b000, 2'b00, 0, "back_idle");

    // Round-robin hand-over from requester 1 to requester 2.
    step(1, 3'b000, 0, 3'b000, 2'b00, 0, "reset_rr");
    td1 = 2'b01; td2 = 2'b11;
    step(0, 3'b110, 0, 3'b010, 2'b01, 1, "rr_first_req1");
    for (int i = 0; i < 4; i++) step(0, 3'b110, 0, 3'b010, 2'b01, 1, "hold_req1");
    step(0, 3'b100, 0, 3'b000, 2'b00, 1, "drop_gap");
    for (int i = 0; i < 3; i++) step(0, 3'b100, 0, 3'b000, 2'b00, 1, "drop_gap_hold");
    step(0, 3'b100, 0, 3'b100, 2'b11, 1, "grant_req2");

    // Preemption by requester 0; late requests during the gap do not shorten it.
    td2 = 2'b10;
    step(0, 3'b100, 0, 3'b100, 2'b10, 1, "dir2_track");
    step(0, 3'b101, 0, 3'b000, 2'b00, 1, "preempt_gap");
    for (int i = 0; i < 3; i++) step(0, 3'b111, 0, 3'b000, 2'b00, 1, "preempt_gap_hold");
    step(0, 3'b111, 0, 3'b001, 2'b11, 1, "grant_req0");
    for (int i = 0; i < 4; i++) step(0, 3'b111, 0, 3'b001, 2'b11, 1, "req0_holds");

    // Pointer now favours requester 1 since requester 2 was served last.
    td1 = 2'b01;
    step(0, 3'b110, 0, 3'b000, 2'b00, 1, "req0_release");
    for (int i = 0; i < 3; i++) step(0, 3'b110, 0, 3'b000, 2'b00, 1, "req0_release_gap");
    step(0, 3'b110, 0, 3'b010, 2'b01, 1, "rr_back_req1");

    // Hold limit of 8 cycles with the other requester waiting.
    for (int i = 0; i < 7; i++) step(0, 3'b110, 0, 3'b010, 2'b01, 1, "wdog_hold");
`ifdef MOTION_ARB_WDOG_EN
    step(0, 3'b110, 0, 3'b000, 2'b00, 1, "wdog_forced_gap");
    for (int i = 0; i < 3; i++) step(0, 3'b110, 0, 3'b000, 2'b00, 1, "wdog_gap_hold");
    step(0, 3'b110, 0, 3'b100, 2'b10, 1, "wdog_grant2");
`else
    for (int i = 0; i < 5; i++) step(0, 3'b110, 0, 3'b010, 2'b01, 1, "no_wdog_hold");
`endif

    // Reset in the middle of a gap, then the pointer must favour requester 1 again.
    step(0, 3'b000, 0, 3'b000, 2'b00, 1, "rel_before_rst");
    step(0, 3'b000, 0, 3'b000, 2'b00, 1, "gap_before_rst");
    step(1, 3'b000, 0, 3'b000, 2'b00, 0, "rst_in_gap");
    step(0, 3'b000, 0, 3'b000, 2'b00, 0, "idle_after_rst");
    step(0, 3'b110, 0, 3'b010, 2'b01, 1, "ptr_reset");

    // Granted request drops while requester 0 rises: one gap, then requester 0.
    step(0, 3'b001, 0, 3'b000, 2'b00, 1, "drop_and_req0");
    for (int i = 0; i < 3; i++) step(0, 3'b001, 0, 3'b000, 2'b00, 1, "drop_and_req0_gap");
    step(0, 3'b001, 0, 3'b001, 2'b11, 1, "req0_after_gap");
    step(0, 3'b000, 0, 3'b000, 2'b00, 1, "final_release");
    for (int i = 0; i < 3; i++) step(0, 3'b000, 0, 3'b000, 2'b00, 1, "final_gap");
    step(0, 3'b000, 0, 3'b000, 2'b00, 0, "final_idle");

    // Zero-length gap still inserts exactly one STOP cycle.
    step(1, 3'b000, 1, 3'b000, 2'b00, 0, "g0_reset");
    step(0, 3'b010, 1, 3'b010, 2'b01, 1, "g0_grant1");
    step(0, 3'b100, 1, 3'b000, 2'b00, 1, "g0_one_stop");
    step(0, 3'b100, 1, 3'b100, 2'b10, 1, "g0_grant2");
    step(0, 3'b000, 1, 3'b000, 2'b00, 1, "g0_gap");
    step(0, 3'b000, 1, 3'b000, 2'b00, 0, "g0_idle");

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
